mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Sits directly downstream of the general register file. It consumes the two register read ports (rs → a, rt → b) and runs mult/multu/div/divu over several cycles. It holds results in HI/LO for mfhi/mflo, which return to the register file write-data path. It also provides a busy signal so the control/hazard logic can stall dependent instructions.

## Interface
- MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO update (≥1)
- DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO update (≥1)

Reset and clock: reset reset, synchronous, active-high; clock clk.

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous active-high reset
- op_valid  input  1  op is issued this cycle
- op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 ignored
- a  input  32  operand from register file RD1 (rs); dividend / multiplicand / mthi-mtlo data
- b  input  32  operand from register file RD2 (rt); divisor / multiplier
- busy  output  1  operation in progress; HI/LO not yet valid
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- Internal state: IDLE / RUN, down-counter (4+ bits, sized to max(MULT_CYCLES, DIV_CYCLES)), latched result pair {res_hi, res_lo} computed from a, b latched at acceptance.
- **Accept rule.** op_valid is accepted only in IDLE (busy=0). op_valid while busy=0 with op 110/111 is a no-op.
- **mult/multu/div/divu accepted.**
  - Latch the op and operands.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- **RUN.** Decrement the counter each edge. On the edge where it would reach 0:
  - write HI/LO;
  - return to IDLE.
- **mthi/mtlo accepted.** hi (or lo) ← a on that edge. The state stays IDLE and busy stays 0.
- **op_valid while busy=1.** Ignored entirely, including mthi/mtlo. No queueing. Upstream must stall.
- **Arithmetic.**
  - mult: {hi,lo} = signed(a)×signed(b), 64-bit.
  - multu: {hi,lo} = unsigned(a)×unsigned(b).
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
  - Divide by zero (b=0, div or divu): full DIV_CYCLES busy period, then HI/LO left unchanged.
- hi/lo hold their previous values throughout RUN. Intermediate results are never visible.

## Timing
- **Reset values.** busy=0, hi=0, lo=0, state IDLE, counter 0.
- **Reset priority.** Reset has priority over everything, including op_valid on the same edge.
- **Reset mid-RUN.** Aborts the operation. No commit ever occurs, and busy=0 after the reset edge.
- **Busy window.** With op accepted at edge N:
  - busy=1 after edge N through edge N+L−1;
  - hi/lo take the new values at edge N+L, and busy=0 after edge N+L (L = MULT_CYCLES or DIV_CYCLES).
  - busy is therefore high for exactly L cycles.
- **Back-to-back issue.** A new op_valid is acceptable in the cycle after busy falls, i.e. on edge N+L+1. An op presented on edge N+L itself is ignored, because busy is still 1 during that cycle.
- **Combinational outputs.** busy, hi and lo are register outputs with no combinational path from the inputs.
- **mthi/mtlo.** One-edge latency.

## Test plan
- Reset, then mult a=0xFFFFFFFF b=0x00000002: busy high 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE. Repeat with multu: hi=0x00000001 lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (−7) b=2: busy exactly 10 cycles, then lo=0xFFFFFFFD hi=0xFFFFFFFF. divu a=7 b=2: lo=3 hi=1. Also div 0x80000000 / 0xFFFFFFFF: lo=0x80000000 hi=0.
- Divide by zero:
  - preload mthi 0x11111111, mtlo 0x22222222;
  - div a=5 b=0 → busy 10 cycles, then hi=0x11111111 lo=0x22222222.
- During div RUN:
  - issue mult, then mthi a=0xDEADBEEF → both ignored;
  - final hi/lo equal the div result;
  - busy falls at cycle 10, not extended.
- Start divu 100/7, assert reset on cycle 3 → busy=0 hi=0 lo=0 after the reset edge, and they remain 0 for 15 further cycles.
- Assert reset and op_valid (mthi a=0x12345678) on the same edge → hi=0. Then:
  - mthi a=0x12345678 → hi=0x12345678 after one edge, busy never rises;
  - mtlo a=0x9ABCDEF0 → lo updated, hi unchanged.

Source files
------------

// File: rtl/mult_div_if.sv
// Issue/result bundle between the register-file read ports and the HI/LO multiply/divide unit.
interface mult_div_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output op_valid, op, a, b, input busy, hi, lo);
  modport slave  (input op_valid, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle mult/multu/div/divu unit with architectural HI/LO registers and a busy stall signal.
//   state | meaning
//   IDLE  | accepting ops; mthi/mtlo write directly
//   RUN   | counting down the latency of a latched mult/div result
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   res_hi, res_lo;
  logic          res_keep;

  logic [63:0] prod;
  logic [31:0] abs_a, abs_b, den_s, den_u, q_mag, r_mag;
  logic [31:0] nxt_hi, nxt_lo;

  // Signed divide works on magnitudes, so 0x80000000 / -1 wraps to 0x80000000 with no special case.
  always_comb begin
    prod   = 64'd0;
    abs_a  = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
    abs_b  = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
    den_s  = (bus.b == 32'd0) ? 32'd1 : abs_b;
    den_u  = (bus.b == 32'd0) ? 32'd1 : bus.b;
    q_mag  = abs_a / den_s;
    r_mag  = abs_a % den_s;
    nxt_hi = 32'd0;
    nxt_lo = 32'd0;
    case (bus.op)
      3'b000: begin
        prod   = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
        nxt_hi = prod[63:32];
        nxt_lo = prod[31:0];
      end
      3'b001: begin
        prod   = {32'd0, bus.a} * {32'd0, bus.b};
        nxt_hi = prod[63:32];
        nxt_lo = prod[31:0];
      end
      3'b010: begin
        nxt_lo = (bus.a[31] ^ bus.b[31]) ? (~q_mag + 32'd1) : q_mag;
        nxt_hi = bus.a[31] ? (~r_mag + 32'd1) : r_mag;
      end
      3'b011: begin
        nxt_lo = bus.a / den_u;
        nxt_hi = bus.a % den_u;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi   <= 32'd0;
      res_lo   <= 32'd0;
      res_keep <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            case (bus.op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                res_hi   <= nxt_hi;
                res_lo   <= nxt_lo;
                res_keep <= bus.op[1] && (bus.b == 32'd0);
                cnt      <= bus.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                state    <= RUN;
              end
              3'b100:  hi_q <= bus.a;
              3'b101:  lo_q <= bus.a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            // Divide by zero still spends the full latency but leaves HI/LO alone.
            if (!res_keep) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: issued long ops queue expected HI/LO and busy length.
module tb_mult_div_unit;
  logic clk;
  logic reset;
  mult_div_if bus();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic rst_at_edge = 1'b0;
  logic prev_busy = 1'b0;
  int   busy_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) rst_at_edge = reset;

  // Monitor: a falling busy marks a completed op; compare against the oldest expectation.
  always @(negedge clk) begin
    if (rst_at_edge) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (bus.busy) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_completion: got hi=%h lo=%h expected no op", bus.hi, bus.lo);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result_hi", bus.hi, e.hi);
          check("result_lo", bus.lo, e.lo);
          check("busy_len", 32'(busy_cnt), 32'(e.len));
        end
        busy_cnt = 0;
      end
      prev_busy = bus.busy;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic issue_long(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input int len);
    exp_t e;
    e.hi = ehi;
    e.lo = elo;
    e.len = len;
    exp_q.push_back(e);
    issue(op, a, b);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", bus.busy, k);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.op_valid = 1'b0;
    bus.op = 3'b000;
    bus.a = 32'd0;
    bus.b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);

    issue_long(3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    wait_idle();
    issue_long(3'b001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5);
    wait_idle();
    issue_long(3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    wait_idle();
    issue_long(3'b011, 32'd7, 32'd2, 32'd1, 32'd3, 10);
    wait_idle();
    issue_long(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
    wait_idle();

    issue(3'b100, 32'h11111111, 32'd0);
    check("mthi_hi", bus.hi, 32'h11111111);
    check("mthi_busy", {31'd0, bus.busy}, 32'd0);
    issue(3'b101, 32'h22222222, 32'd0);
    check("mtlo_lo", bus.lo, 32'h22222222);
    issue(3'b110, 32'h33333333, 32'd0);
    check("nop_busy", {31'd0, bus.busy}, 32'd0);
    check("nop_hi", bus.hi, 32'h11111111);
    issue_long(3'b010, 32'd5, 32'd0, 32'h11111111, 32'h22222222, 10);
    wait_idle();

    // Ops during RUN, including one on the final busy edge, must all be dropped.
    issue_long(3'b010, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 10);
    issue(3'b000, 32'd3, 32'd3);
    issue(3'b100, 32'hDEADBEEF, 32'd0);
    check("run_hi_held", bus.hi, 32'h11111111);
    repeat (7) @(posedge clk);
    #1;
    issue(3'b000, 32'd3, 32'd3);
    check("edge_nl_busy", {31'd0, bus.busy}, 32'd0);
    check("edge_nl_hi", bus.hi, 32'hFFFFFFFE);
    check("edge_nl_lo", bus.lo, 32'hFFFFFFF2);
    issue_long(3'b001, 32'd3, 32'd4, 32'd0, 32'd12, 5);
    check("b2b_busy", {31'd0, bus.busy}, 32'd1);
    wait_idle();

    issue(3'b011, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      check("abort_hold_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_hold_hi", bus.hi, 32'd0);
      check("abort_hold_lo", bus.lo, 32'd0);
    end

    issue(3'b100, 32'hAAAAAAAA, 32'd0);
    check("pre_rst_hi", bus.hi, 32'hAAAAAAAA);
    reset = 1'b1;
    issue(3'b100, 32'h12345678, 32'd0);
    reset = 1'b0;
    check("rst_prio_hi", bus.hi, 32'd0);
    issue(3'b100, 32'h12345678, 32'd0);
    check("mthi2_hi", bus.hi, 32'h12345678);
    check("mthi2_busy", {31'd0, bus.busy}, 32'd0);
    issue(3'b101, 32'h9ABCDEF0, 32'd0);
    check("mtlo2_lo", bus.lo, 32'h9ABCDEF0);
    check("mtlo2_hi", bus.hi, 32'h12345678);
    check("mtlo2_busy", {31'd0, bus.busy}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
